// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
// Module   : time_pkg
// Purpose  : Shared definitions for the alarm/time path: BCD field widths,
//            packed-time layout, entry FSM states, field codes and defaults.
// Revision : 1.0 - initial release
// ============================================================================
package time_pkg;

    // Width of each BCD digit field in the packed time word
    localparam int HR_T_W = 2;
    localparam int HR_U_W = 4;
    localparam int MN_T_W = 3;
    localparam int MN_U_W = 4;
    localparam int SC_T_W = 3;
    localparam int SC_U_W = 4;
    localparam int TIME_W = HR_T_W + HR_U_W + MN_T_W + MN_U_W + SC_T_W + SC_U_W;

    // Bit offsets of each digit within the packed time word
    localparam int SC_U_OFF = 0;
    localparam int SC_T_OFF = SC_U_OFF + SC_U_W;
    localparam int MN_U_OFF = SC_T_OFF + SC_T_W;
    localparam int MN_T_OFF = MN_U_OFF + MN_U_W;
    localparam int HR_U_OFF = MN_T_OFF + MN_T_W;
    localparam int HR_T_OFF = HR_U_OFF + HR_U_W;

    // Alarm-entry state machine encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOUR   = 3'd1,
        ST_MIN    = 3'd2,
        ST_SEC    = 3'd3,
        ST_AMPM   = 3'd4,
        ST_COMMIT = 3'd5
    } entry_state_t;

    // Field codes presented on the display-blink hint
    localparam logic [1:0] FIELD_HOUR = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_SEC  = 2'd2;
    localparam logic [1:0] FIELD_AMPM = 2'd3;

    // Starting hour for a fresh edit: 12 in 12h mode, 00 in 24h mode
    localparam logic [HR_T_W-1:0] HR_T_DEF_12H = 2'd1;
    localparam logic [HR_U_W-1:0] HR_U_DEF_12H = 4'd2;
    localparam logic [HR_T_W-1:0] HR_T_DEF_24H = 2'd0;
    localparam logic [HR_U_W-1:0] HR_U_DEF_24H = 4'd0;

    // Hour bounds per mode (inclusive)
    localparam logic [HR_T_W-1:0] HR_T_MIN_12H = 2'd0;
    localparam logic [HR_U_W-1:0] HR_U_MIN_12H = 4'd1;
    localparam logic [HR_T_W-1:0] HR_T_MAX_12H = 2'd1;
    localparam logic [HR_U_W-1:0] HR_U_MAX_12H = 4'd2;
    localparam logic [HR_T_W-1:0] HR_T_MIN_24H = 2'd0;
    localparam logic [HR_U_W-1:0] HR_U_MIN_24H = 4'd0;
    localparam logic [HR_T_W-1:0] HR_T_MAX_24H = 2'd2;
    localparam logic [HR_U_W-1:0] HR_U_MAX_24H = 4'd3;

    // Minute/second bounds: 00..59
    localparam logic [MN_T_W-1:0] MS_T_MIN = 3'd0;
    localparam logic [MN_U_W-1:0] MS_U_MIN = 4'd0;
    localparam logic [MN_T_W-1:0] MS_T_MAX = 3'd5;
    localparam logic [MN_U_W-1:0] MS_U_MAX = 4'd9;

    // Assemble the packed BCD time word from its six digits
    function automatic logic [TIME_W-1:0] pack_time(
        input logic [HR_T_W-1:0] hr_t,
        input logic [HR_U_W-1:0] hr_u,
        input logic [MN_T_W-1:0] mn_t,
        input logic [MN_U_W-1:0] mn_u,
        input logic [SC_T_W-1:0] sc_t,
        input logic [SC_U_W-1:0] sc_u
    );
        return {hr_t, hr_u, mn_t, mn_u, sc_t, sc_u};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_field_inc.sv
`default_nettype none
// ============================================================================
// Module   : bcd_field_inc
// Purpose  : Combinational next value of a tens/units BCD pair, wrapping from
//            the max bound back to the min bound.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_field_inc #(
    parameter int T_W = 3,
    parameter int U_W = 4
) (
    input  logic [T_W-1:0] tens_in,
    input  logic [U_W-1:0] units_in,
    input  logic [T_W-1:0] min_t,
    input  logic [U_W-1:0] min_u,
    input  logic [T_W-1:0] max_t,
    input  logic [U_W-1:0] max_u,
    output logic [T_W-1:0] tens_out,
    output logic [U_W-1:0] units_out
);

    // Wrap at the upper bound, otherwise a decimal increment with units carry
    always_comb begin
        tens_out  = tens_in;
        units_out = units_in + U_W'(1);
        if ((tens_in == max_t) && (units_in == max_u)) begin
            tens_out  = min_t;
            units_out = min_u;
        end else if (units_in == U_W'(9)) begin
            tens_out  = tens_in + T_W'(1);
            units_out = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_entry.sv
`default_nettype none
// ============================================================================
// Module   : alarm_entry
// Purpose  : Two-button alarm programmer. Steps through hour/min/sec (and
//            AM/PM in 12h mode), then presents the committed alarm with a
//            one-cycle set_alarm strobe.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_entry
    import time_pkg::*;
#(
    parameter int ALARM_ID_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode12h,
    input  logic                  edit_en,
    input  logic                  button1,
    input  logic                  button2,
    input  logic [ALARM_ID_W-1:0] slot_in,
    output logic [TIME_W-1:0]     stime_alarm,
    output logic                  sam_pm,
    output logic                  set_alarm,
    output logic [ALARM_ID_W-1:0] alarm_id,
    output logic                  editing,
    output logic [1:0]            field
);

    entry_state_t state, state_next;

    // Edge-detect pipeline: first stage is the sampled level, second the history
    logic en_q, en_q2, b1_q, b1_q2, b2_q, b2_q2;
    logic en_rise, b1_rise, b2_rise;

    // Working registers for the alarm being edited
    logic [HR_T_W-1:0]     hr_t;
    logic [HR_U_W-1:0]     hr_u;
    logic [MN_T_W-1:0]     mn_t;
    logic [MN_U_W-1:0]     mn_u;
    logic [SC_T_W-1:0]     sc_t;
    logic [SC_U_W-1:0]     sc_u;
    logic                  pm;
    logic                  mode_l;
    logic [ALARM_ID_W-1:0] slot_l;

    // FSM control strobes
    logic load_defaults, inc_hr, inc_mn, inc_sc, toggle_pm, load_out;

    // Candidate next values from the BCD incrementers
    logic [HR_T_W-1:0] hr12_t, hr24_t;
    logic [HR_U_W-1:0] hr12_u, hr24_u;
    logic [MN_T_W-1:0] mn_t_nx;
    logic [MN_U_W-1:0] mn_u_nx;
    logic [SC_T_W-1:0] sc_t_nx;
    logic [SC_U_W-1:0] sc_u_nx;

    assign en_rise = en_q & ~en_q2;
    assign b1_rise = b1_q & ~b1_q2;
    assign b2_rise = b2_q & ~b2_q2;

    bcd_field_inc #(.T_W(HR_T_W), .U_W(HR_U_W)) u_hr12_inc (
        .tens_in (hr_t),         .units_in (hr_u),
        .min_t   (HR_T_MIN_12H), .min_u    (HR_U_MIN_12H),
        .max_t   (HR_T_MAX_12H), .max_u    (HR_U_MAX_12H),
        .tens_out(hr12_t),       .units_out(hr12_u)
    );

    bcd_field_inc #(.T_W(HR_T_W), .U_W(HR_U_W)) u_hr24_inc (
        .tens_in (hr_t),         .units_in (hr_u),
        .min_t   (HR_T_MIN_24H), .min_u    (HR_U_MIN_24H),
        .max_t   (HR_T_MAX_24H), .max_u    (HR_U_MAX_24H),
        .tens_out(hr24_t),       .units_out(hr24_u)
    );

    bcd_field_inc #(.T_W(MN_T_W), .U_W(MN_U_W)) u_mn_inc (
        .tens_in (mn_t),     .units_in (mn_u),
        .min_t   (MS_T_MIN), .min_u    (MS_U_MIN),
        .max_t   (MS_T_MAX), .max_u    (MS_U_MAX),
        .tens_out(mn_t_nx),  .units_out(mn_u_nx)
    );

    bcd_field_inc #(.T_W(SC_T_W), .U_W(SC_U_W)) u_sc_inc (
        .tens_in (sc_t),     .units_in (sc_u),
        .min_t   (MS_T_MIN), .min_u    (MS_U_MIN),
        .max_t   (MS_T_MAX), .max_u    (MS_U_MAX),
        .tens_out(sc_t_nx),  .units_out(sc_u_nx)
    );

    // Two-stage sampling of the control inputs for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q  <= 1'b0;
            en_q2 <= 1'b0;
            b1_q  <= 1'b0;
            b1_q2 <= 1'b0;
            b2_q  <= 1'b0;
            b2_q2 <= 1'b0;
        end else begin
            en_q  <= edit_en;
            en_q2 <= en_q;
            b1_q  <= button1;
            b1_q2 <= b1_q;
            b2_q  <= button2;
            b2_q2 <= b2_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state outputs; abort beats advance beats increment
    always_comb begin
        state_next    = state;
        load_defaults = 1'b0;
        inc_hr        = 1'b0;
        inc_mn        = 1'b0;
        inc_sc        = 1'b0;
        toggle_pm     = 1'b0;
        load_out      = 1'b0;
        editing       = 1'b0;
        field         = FIELD_HOUR;
        set_alarm     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_rise) begin
                    state_next    = ST_HOUR;
                    load_defaults = 1'b1;
                end
            end
            ST_HOUR: begin
                editing = 1'b1;
                field   = FIELD_HOUR;
                if (!en_q) begin
                    state_next = ST_IDLE;
                end else if (b1_rise) begin
                    state_next = ST_MIN;
                end else if (b2_rise) begin
                    inc_hr = 1'b1;
                end
            end
            ST_MIN: begin
                editing = 1'b1;
                field   = FIELD_MIN;
                if (!en_q) begin
                    state_next = ST_IDLE;
                end else if (b1_rise) begin
                    state_next = ST_SEC;
                end else if (b2_rise) begin
                    inc_mn = 1'b1;
                end
            end
            ST_SEC: begin
                editing = 1'b1;
                field   = FIELD_SEC;
                if (!en_q) begin
                    state_next = ST_IDLE;
                end else if (b1_rise) begin
                    if (mode_l) begin
                        state_next = ST_AMPM;
                    end else begin
                        state_next = ST_COMMIT;
                        load_out   = 1'b1;
                    end
                end else if (b2_rise) begin
                    inc_sc = 1'b1;
                end
            end
            ST_AMPM: begin
                editing = 1'b1;
                field   = FIELD_AMPM;
                if (!en_q) begin
                    state_next = ST_IDLE;
                end else if (b1_rise) begin
                    state_next = ST_COMMIT;
                    load_out   = 1'b1;
                end else if (b2_rise) begin
                    toggle_pm = 1'b1;
                end
            end
            ST_COMMIT: begin
                set_alarm  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Working registers: loaded with mode defaults at edit entry, then stepped by button2
    always_ff @(posedge clk) begin
        if (!rst) begin
            hr_t   <= '0;
            hr_u   <= '0;
            mn_t   <= '0;
            mn_u   <= '0;
            sc_t   <= '0;
            sc_u   <= '0;
            pm     <= 1'b0;
            mode_l <= 1'b0;
            slot_l <= '0;
        end else if (load_defaults) begin
            mode_l <= mode12h;
            slot_l <= slot_in;
            hr_t   <= mode12h ? HR_T_DEF_12H : HR_T_DEF_24H;
            hr_u   <= mode12h ? HR_U_DEF_12H : HR_U_DEF_24H;
            mn_t   <= '0;
            mn_u   <= '0;
            sc_t   <= '0;
            sc_u   <= '0;
            pm     <= 1'b0;
        end else begin
            if (inc_hr) begin
                hr_t <= mode_l ? hr12_t : hr24_t;
                hr_u <= mode_l ? hr12_u : hr24_u;
            end
            if (inc_mn) begin
                mn_t <= mn_t_nx;
                mn_u <= mn_u_nx;
            end
            if (inc_sc) begin
                sc_t <= sc_t_nx;
                sc_u <= sc_u_nx;
            end
            if (toggle_pm) begin
                pm <= ~pm;
            end
        end
    end

    // Committed alarm outputs, updated on the edge that enters COMMIT and held otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            stime_alarm <= '0;
            sam_pm      <= 1'b0;
            alarm_id    <= '0;
        end else if (load_out) begin
            stime_alarm <= pack_time(hr_t, hr_u, mn_t, mn_u, sc_t, sc_u);
            sam_pm      <= pm & mode_l;
            alarm_id    <= slot_l;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_entry
// Purpose  : Directed bench for alarm_entry. Expected commits are queued as
//            stimulus is issued; a monitor pops and compares on set_alarm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_entry;

    localparam int ALARM_ID_W = 2;

    typedef struct packed {
        logic [19:0]           t;
        logic                  pm;
        logic [ALARM_ID_W-1:0] id;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  mode12h;
    logic                  edit_en;
    logic                  button1;
    logic                  button2;
    logic [ALARM_ID_W-1:0] slot_in;
    logic [19:0]           stime_alarm;
    logic                  sam_pm;
    logic                  set_alarm;
    logic [ALARM_ID_W-1:0] alarm_id;
    logic                  editing;
    logic [1:0]            field;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    logic prev_set;

    alarm_entry #(.ALARM_ID_W(ALARM_ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode12h    (mode12h),
        .edit_en    (edit_en),
        .button1    (button1),
        .button2    (button2),
        .slot_in    (slot_in),
        .stime_alarm(stime_alarm),
        .sam_pm     (sam_pm),
        .set_alarm  (set_alarm),
        .alarm_id   (alarm_id),
        .editing    (editing),
        .field      (field)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press1();
        button1 = 1'b1;
        repeat (2) tick();
        button1 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic press_both();
        button1 = 1'b1;
        button2 = 1'b1;
        repeat (2) tick();
        button1 = 1'b0;
        button2 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic incr(input int n);
        for (int i = 0; i < n; i++) begin
            button2 = 1'b1;
            repeat (2) tick();
            button2 = 1'b0;
            repeat (2) tick();
        end
    endtask

    task automatic enter(input logic m, input logic [ALARM_ID_W-1:0] s);
        mode12h = m;
        slot_in = s;
        edit_en = 1'b1;
        repeat (3) tick();
    endtask

    task automatic leave();
        edit_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic expect_commit(input logic [19:0] t, input logic pm, input logic [ALARM_ID_W-1:0] id);
        exp_t e;
        e.t  = t;
        e.pm = pm;
        e.id = id;
        exp_q.push_back(e);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        prev_set = 1'b0;
        rst      = 1'b0;
        mode12h  = 1'b0;
        edit_en  = 1'b0;
        button1  = 1'b0;
        button2  = 1'b0;
        slot_in  = '0;

        fork
            // Stimulus
            begin
                repeat (3) tick();
                chk("reset_stime", 32'(stime_alarm), 32'h0);
                chk("reset_pm", 32'(sam_pm), 32'h0);
                chk("reset_set", 32'(set_alarm), 32'h0);
                chk("reset_id", 32'(alarm_id), 32'h0);
                chk("reset_editing", 32'(editing), 32'h0);
                chk("reset_field", 32'(field), 32'h0);
                rst = 1'b1;
                repeat (2) tick();

                // 24h entry 13:34:56 into slot 2
                enter(1'b0, 2'd2);
                chk("enter_editing", 32'(editing), 32'h1);
                chk("enter_field", 32'(field), 32'h0);
                incr(13);
                press1();
                chk("min_field", 32'(field), 32'h1);
                incr(34);
                press1();
                chk("sec_field", 32'(field), 32'h2);
                incr(56);
                expect_commit(20'h4DA56, 1'b0, 2'd2);
                press1();
                chk("post_commit_editing", 32'(editing), 32'h0);
                leave();

                // 24h wrap: hour 24 steps, minutes 60 steps
                enter(1'b0, 2'd1);
                incr(24);
                press1();
                incr(60);
                press1();
                expect_commit(20'h00000, 1'b0, 2'd1);
                press1();
                leave();

                // 12h default 12:00:00 AM
                enter(1'b1, 2'd3);
                press1();
                press1();
                press1();
                chk("ampm_field", 32'(field), 32'h3);
                expect_commit(20'h48000, 1'b0, 2'd3);
                press1();
                leave();

                // 12h: 11 hour steps (12->11), PM toggle
                enter(1'b1, 2'd3);
                incr(11);
                press1();
                press1();
                press1();
                incr(1);
                expect_commit(20'h44000, 1'b1, 2'd3);
                press1();
                leave();

                // Abort mid-edit leaves committed outputs alone
                enter(1'b0, 2'd0);
                incr(5);
                leave();
                chk("abort_editing", 32'(editing), 32'h0);
                chk("abort_stime", 32'(stime_alarm), 32'h44000);
                chk("abort_pm", 32'(sam_pm), 32'h1);
                chk("abort_id", 32'(alarm_id), 32'h3);

                // Simultaneous advance+increment in MIN: advance wins
                enter(1'b0, 2'd0);
                press1();
                incr(2);
                press_both();
                chk("both_field", 32'(field), 32'h2);
                expect_commit(20'h00100, 1'b0, 2'd0);
                press1();
                leave();

                // Reset mid-SEC
                enter(1'b0, 2'd1);
                press1();
                press1();
                chk("pre_reset_field", 32'(field), 32'h2);
                rst     = 1'b0;
                edit_en = 1'b0;
                tick();
                chk("rst_stime", 32'(stime_alarm), 32'h0);
                chk("rst_pm", 32'(sam_pm), 32'h0);
                chk("rst_id", 32'(alarm_id), 32'h0);
                chk("rst_editing", 32'(editing), 32'h0);
                chk("rst_field", 32'(field), 32'h0);
                chk("rst_set", 32'(set_alarm), 32'h0);
                rst = 1'b1;
                repeat (2) tick();

                // mode12h toggled mid-edit is ignored
                enter(1'b0, 2'd2);
                incr(1);
                mode12h = 1'b1;
                press1();
                press1();
                chk("mode_sec_field", 32'(field), 32'h2);
                expect_commit(20'h04000, 1'b0, 2'd2);
                press1();
                chk("mode_done_field", 32'(field), 32'h0);
                chk("mode_done_editing", 32'(editing), 32'h0);
                leave();
                mode12h = 1'b0;
                repeat (4) tick();
            end
            // Monitor: compare each strobe against the oldest queued commit
            begin
                forever begin
                    @(negedge clk);
                    if (rst && set_alarm) begin
                        chk("strobe_width", 32'(prev_set), 32'h0);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_strobe: got set_alarm=1, expected no commit");
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("commit_stime", 32'(stime_alarm), 32'(e.t));
                            chk("commit_pm", 32'(sam_pm), 32'(e.pm));
                            chk("commit_id", 32'(alarm_id), 32'(e.id));
                        end
                    end
                    prev_set = set_alarm;
                end
            end
            // Watchdog
            begin
                repeat (20000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL timeout: got no end of stimulus, expected completion within 20000 cycles");
            end
        join_any
        disable fork;

        chk("pending_commits", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_entry.md
Name: alarm_entry

Overview:
- Button-driven alarm programmer; the writer side of the alarm-load interface that the clock core (time_view) reads.
- The user steps through hour/min/sec (and AM/PM in 12h mode) fields with two buttons.
- On commit, drives a packed BCD time on stime_alarm, the meridiem on sam_pm and a slot number on alarm_id, qualified by a one-cycle set_alarm strobe.
- Sits between the front-panel buttons and time_view's alarm inputs.

Parameters:
- ALARM_ID_W, 2, width of alarm_id (up to 2**ALARM_ID_W alarm slots).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- mode12h  in  1  1 = 12h entry, 0 = 24h; latched at edit entry.
- edit_en  in  1  level; rising edge starts an edit, low aborts it.
- button1  in  1  level; rising edge advances to the next field.
- button2  in  1  level; rising edge increments the current field.
- slot_in  in  ALARM_ID_W  target slot; latched at edit entry.
- stime_alarm  out  20  {hr_t[1:0], hr_u[3:0], mn_t[2:0], mn_u[3:0], sc_t[2:0], sc_u[3:0]}, BCD.
- sam_pm  out  1  0 = AM, 1 = PM; always 0 for a 24h commit.
- set_alarm  out  1  one-cycle commit strobe.
- alarm_id  out  ALARM_ID_W  committed slot.
- editing  out  1  high in any edit state.
- field  out  2  0 = hour, 1 = min, 2 = sec, 3 = AM/PM (display-blink hint).

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; stime_alarm=0, sam_pm=0, set_alarm=0, alarm_id=0, editing=0, field=0; working registers cleared; edge-detect history regs cleared.
- Edge detection: each of edit_en, button1, button2 is registered once; rise = cur & ~prev. Inputs are assumed already synchronised and debounced.
- States: IDLE, HOUR, MIN, SEC, AMPM, COMMIT.
- IDLE:
  - On edit_en rise, go to HOUR.
  - Latch mode12h and slot_in.
  - Load working time: 12:00:00 AM if 12h, 00:00:00 if 24h.
- HOUR/MIN/SEC/AMPM:
  - button2 rise increments the current field.
  - button1 rise advances the field: HOUR→MIN→SEC→AMPM (12h) or SEC→COMMIT (24h); AMPM→COMMIT.
  - button1 and button2 rising in the same cycle: advance wins, the increment is dropped.
- Increment rules:
  - hour 24h: 00..23, 23→00.
  - hour 12h: 01..12, 12→01. The AM/PM flag does not change on hour wrap.
  - min and sec: 00..59, 59→00. Units 9→0 carries into tens within the field only; no carry between fields.
  - AMPM field: toggles the PM flag.
- Entering COMMIT:
  - In the same clock edge, stime_alarm, sam_pm (PM flag & latched 12h mode) and alarm_id load from the working regs.
  - In COMMIT: set_alarm=1 for exactly one cycle, then return to IDLE (set_alarm=0).
  - Outputs hold until the next commit.
- Abort: edit_en low in any edit state → IDLE next cycle. No strobe; committed outputs unchanged. COMMIT itself is not abortable.
- editing = state ∈ {HOUR, MIN, SEC, AMPM}. field follows the state (0 in IDLE/COMMIT).
- Changes to mode12h or slot_in during an edit are ignored.
- Reset has priority over everything, including mid-edit and COMMIT.
- Latency: the button1 rise registered on the last field → set_alarm high 2 cycles after the raw button1 edge (1 cycle for edge detect, 1 for state).

Decomposition:
- Package time_pkg:
  - field widths HR_T_W=2, HR_U_W=4, MN_T_W=3, MN_U_W=4, SC_T_W=3, SC_U_W=4.
  - packed-time field offsets.
  - state enum.
  - field codes.
  - 12h/24h default constants.
  - The package is shared with time_view.
- One sub-module, bcd_field_inc: combinational next-value for a tens/units BCD pair, given min/max bounds. Instantiated for hour (two bound sets) and for min/sec.

Test Plan:
- 24h entry, slot_in=2, hour +13, min +34, sec +56, commit → one-cycle set_alarm; stime_alarm=0x4DA56, sam_pm=0, alarm_id=2.
- 24h wrap: 24 hour increments → hour 00; 60 min increments → 00; commit → stime_alarm=0x00000.
- 12h entry: no increments, commit via AMPM with no toggle → 0x48000, sam_pm=0. Second edit: hour +11 (12→11), AMPM toggle once → 0x44000, sam_pm=1.
- Abort: enter, hour +5, drop edit_en → returns to IDLE, set_alarm never asserts, stime_alarm keeps its prior value.
- Simultaneous button1+button2 rise in MIN → field becomes SEC, minutes unchanged. rst low mid-SEC → all outputs 0 next cycle, state IDLE.
- mode12h toggled during a 24h edit → AMPM still skipped; committed sam_pm=0.
